// File: rtl/if_id_stage_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : if_id_stage_ctrl_pkg
// Brief   : Shared types and constants for the IF/ID stage controller.
// Revision: 1.0 - initial release
// ============================================================================
package if_id_stage_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_t;

   localparam int          CTRL_W    = 10;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   localparam int RS_MSB = 25;
   localparam int RS_LSB = 21;
   localparam int RT_MSB = 20;
   localparam int RT_LSB = 16;

endpackage
`default_nettype wire

// File: rtl/if_id_stage_ctrl_pipe_reg.sv
`default_nettype none
// ============================================================================
// Module  : pipe_reg
// Brief   : Pipeline register with load enable and synchronous clear.
// Revision: 1.0 - initial release
// ============================================================================
module pipe_reg #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_en,
   input  logic             i_clr,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // Clear outranks the enable so a flush wins over a load in the same cycle.
   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule
`default_nettype wire

// File: rtl/if_id_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : if_id_stage_ctrl
// Brief   : PC, IF/ID and ID/EX control registers with stall/flush FSM.
//           Define STALL_COUNTER_EN to add the stall_cycles counter port.
// Revision: 1.0 - initial release
// ============================================================================
module if_id_stage_ctrl
   import if_id_stage_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              PCWrite,
   input  logic              IFIDWrite,
   input  logic              HazMuxCtrl,
   input  logic              branch_taken,
   input  logic [31:0]       branch_target,
   input  logic [31:0]       instr_in,
   input  logic [CTRL_W-1:0] ctrl_in,
   output logic [31:0]       pc,
   output logic [31:0]       IFID_instr,
   output logic [31:0]       IFID_pc4,
   output logic [4:0]        IFID_rs,
   output logic [4:0]        IFID_rt,
   output logic              IFID_valid,
   output logic [CTRL_W-1:0] IDEX_ctrl,
   output logic [1:0]        state
`ifdef STALL_COUNTER_EN
   ,
   output logic [31:0]       stall_cycles
`endif
);

   logic [31:0] r_pc;
   state_t      r_state;
   logic        w_redirect;
   logic [31:0] w_pc_plus4;

   // A taken branch only redirects when the hazard unit lets the PC move.
   assign w_redirect = branch_taken & PCWrite;
   assign w_pc_plus4 = r_pc + 32'd4;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc    <= RESET_PC;
         r_state <= ST_RUN;
      end else if (w_redirect) begin
         r_pc    <= branch_target;
         r_state <= ST_FLUSH;
      end else if (PCWrite) begin
         r_pc    <= w_pc_plus4;
         r_state <= ST_RUN;
      end else begin
         r_state <= ST_STALL;
      end
   end

   // Instruction and valid share one register so a flush clears both at once.
   pipe_reg #(.WIDTH(33)) u_ifid_instr (
      .clk   (clk),
      .reset (reset),
      .i_en  (IFIDWrite),
      .i_clr (w_redirect),
      .i_d   ({1'b1, instr_in}),
      .o_q   ({IFID_valid, IFID_instr})
   );

   pipe_reg #(.WIDTH(32)) u_ifid_pc4 (
      .clk   (clk),
      .reset (reset),
      .i_en  (IFIDWrite & ~w_redirect),
      .i_clr (1'b0),
      .i_d   (w_pc_plus4),
      .o_q   (IFID_pc4)
   );

   pipe_reg #(.WIDTH(CTRL_W)) u_idex_ctrl (
      .clk   (clk),
      .reset (reset),
      .i_en  (1'b1),
      .i_clr (HazMuxCtrl | ~IFID_valid),
      .i_d   (ctrl_in),
      .o_q   (IDEX_ctrl)
   );

   assign pc      = r_pc;
   assign state   = r_state;
   assign IFID_rs = IFID_instr[RS_MSB:RS_LSB];
   assign IFID_rt = IFID_instr[RT_MSB:RT_LSB];

`ifdef STALL_COUNTER_EN
   logic [31:0] r_stall_cycles;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cycles <= 32'd0;
      end else if (!PCWrite && (r_stall_cycles != 32'hFFFF_FFFF)) begin
         r_stall_cycles <= r_stall_cycles + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_if_id_stage_ctrl
// Brief   : Directed vector table, corner sequences and random run vs model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_if_id_stage_ctrl;

   logic        clk;
   logic        reset;
   logic        PCWrite, IFIDWrite, HazMuxCtrl, branch_taken;
   logic [31:0] branch_target, instr_in;
   logic [9:0]  ctrl_in;
   logic [31:0] pc, IFID_instr, IFID_pc4;
   logic [4:0]  IFID_rs, IFID_rt;
   logic        IFID_valid;
   logic [9:0]  IDEX_ctrl;
   logic [1:0]  state;
`ifdef STALL_COUNTER_EN
   logic [31:0] stall_cycles;
`endif

   if_id_stage_ctrl #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .reset         (reset),
      .PCWrite       (PCWrite),
      .IFIDWrite     (IFIDWrite),
      .HazMuxCtrl    (HazMuxCtrl),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .instr_in      (instr_in),
      .ctrl_in       (ctrl_in),
      .pc            (pc),
      .IFID_instr    (IFID_instr),
      .IFID_pc4      (IFID_pc4),
      .IFID_rs       (IFID_rs),
      .IFID_rt       (IFID_rt),
      .IFID_valid    (IFID_valid),
      .IDEX_ctrl     (IDEX_ctrl),
      .state         (state)
`ifdef STALL_COUNTER_EN
      ,
      .stall_cycles  (stall_cycles)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Reference model: architectural state, updated once per clock edge.
   logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
   logic        m_valid;
   logic [9:0]  m_ctrl;
   logic [1:0]  m_state;

   typedef struct {
      logic        rst, pcw, ifw, haz, bt;
      logic [31:0] tgt, ins;
      logic [9:0]  ctl;
      logic [31:0] e_pc, e_instr, e_pc4;
      logic        e_valid;
      logic [9:0]  e_ctrl;
      logic [1:0]  e_state;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic model_edge(input logic r, pcw, ifw, haz, bt,
                             input logic [31:0] tgt, ins, input logic [9:0] c);
      if (r) begin
         m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
         m_ctrl = 10'h0; m_state = 2'd0; m_cnt = 32'h0;
      end else begin
         m_ctrl = (haz || !m_valid) ? 10'h0 : c;
         if (!pcw && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
         if (bt && pcw) begin
            m_pc = tgt; m_instr = 32'h0; m_valid = 1'b0; m_state = 2'd2;
         end else begin
            if (ifw) begin
               m_instr = ins; m_pc4 = m_pc + 4; m_valid = 1'b1;
            end
            if (pcw) m_pc = m_pc + 4;
            m_state = pcw ? 2'd0 : 2'd1;
         end
      end
   endtask

   task automatic step(input logic r, pcw, ifw, haz, bt,
                       input logic [31:0] tgt, ins, input logic [9:0] c);
      reset = r; PCWrite = pcw; IFIDWrite = ifw; HazMuxCtrl = haz;
      branch_taken = bt; branch_target = tgt; instr_in = ins; ctrl_in = c;
      @(posedge clk);
      model_edge(r, pcw, ifw, haz, bt, tgt, ins, c);
      #1;
   endtask

   task automatic chk_model();
      chk("pc", pc, m_pc);
      chk("IFID_instr", IFID_instr, m_instr);
      chk("IFID_pc4", IFID_pc4, m_pc4);
      chk("IFID_valid", {31'h0, IFID_valid}, {31'h0, m_valid});
      chk("IDEX_ctrl", {22'h0, IDEX_ctrl}, {22'h0, m_ctrl});
      chk("state", {30'h0, state}, {30'h0, m_state});
      chk("IFID_rs", {27'h0, IFID_rs}, {27'h0, m_instr[25:21]});
      chk("IFID_rt", {27'h0, IFID_rt}, {27'h0, m_instr[20:16]});
`ifdef STALL_COUNTER_EN
      chk("stall_cycles", stall_cycles, m_cnt);
`endif
   endtask

   vec_t vecs[13];

   initial begin
      //           rst pcw ifw haz bt  tgt           ins           ctl     pc            instr         pc4           v     ctrl    st
      vecs[0]  = '{1, 0, 0, 0, 0, 32'h0,        32'h0,        10'h000, 32'h0,        32'h0,        32'h0,  0, 10'h000, 2'd0};
      vecs[1]  = '{0, 1, 1, 0, 0, 32'h0,        32'h11111111, 10'h3FF, 32'h4,        32'h11111111, 32'h4,  1, 10'h000, 2'd0};
      vecs[2]  = '{0, 1, 1, 0, 0, 32'h0,        32'h8D0A0000, 10'h155, 32'h8,        32'h8D0A0000, 32'h8,  1, 10'h155, 2'd0};
      vecs[3]  = '{0, 0, 0, 1, 0, 32'h0,        32'h22222222, 10'h2AA, 32'h8,        32'h8D0A0000, 32'h8,  1, 10'h000, 2'd1};
      vecs[4]  = '{0, 1, 1, 0, 0, 32'h0,        32'h33333333, 10'h0F0, 32'hC,        32'h33333333, 32'hC,  1, 10'h0F0, 2'd0};
      vecs[5]  = '{0, 1, 1, 0, 1, 32'h40,       32'h44444444, 10'h00F, 32'h40,       32'h0,        32'hC,  0, 10'h00F, 2'd2};
      vecs[6]  = '{0, 1, 1, 0, 0, 32'h0,        32'h55555555, 10'h1C3, 32'h44,       32'h55555555, 32'h44, 1, 10'h000, 2'd0};
      vecs[7]  = '{0, 0, 0, 0, 1, 32'h80,       32'h0,        10'h0AA, 32'h44,       32'h55555555, 32'h44, 1, 10'h0AA, 2'd1};
      vecs[8]  = '{0, 1, 0, 0, 1, 32'hFFFFFFFC, 32'h0,        10'h011, 32'hFFFFFFFC, 32'h0,        32'h44, 0, 10'h011, 2'd2};
      vecs[9]  = '{0, 1, 1, 0, 0, 32'h0,        32'h66666666, 10'h3FF, 32'h0,        32'h66666666, 32'h0,  1, 10'h000, 2'd0};
      vecs[10] = '{0, 1, 1, 0, 1, 32'h100,      32'h77777777, 10'h123, 32'h100,      32'h0,        32'h0,  0, 10'h123, 2'd2};
      vecs[11] = '{0, 0, 0, 0, 0, 32'h0,        32'h0,        10'h3FF, 32'h100,      32'h0,        32'h0,  0, 10'h000, 2'd1};
      vecs[12] = '{1, 0, 1, 0, 1, 32'h200,      32'h88888888, 10'h3FF, 32'h0,        32'h0,        32'h0,  0, 10'h000, 2'd0};

      m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_ctrl = 0; m_state = 0; m_cnt = 0;

      for (int i = 0; i < 13; i++) begin
         step(vecs[i].rst, vecs[i].pcw, vecs[i].ifw, vecs[i].haz, vecs[i].bt,
              vecs[i].tgt, vecs[i].ins, vecs[i].ctl);
         chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
         chk($sformatf("v%0d_instr", i), IFID_instr, vecs[i].e_instr);
         chk($sformatf("v%0d_pc4", i), IFID_pc4, vecs[i].e_pc4);
         chk($sformatf("v%0d_valid", i), {31'h0, IFID_valid}, {31'h0, vecs[i].e_valid});
         chk($sformatf("v%0d_ctrl", i), {22'h0, IDEX_ctrl}, {22'h0, vecs[i].e_ctrl});
         chk($sformatf("v%0d_state", i), {30'h0, state}, {30'h0, vecs[i].e_state});
         chk($sformatf("v%0d_rs", i), {27'h0, IFID_rs}, {27'h0, vecs[i].e_instr[25:21]});
         chk($sformatf("v%0d_rt", i), {27'h0, IFID_rt}, {27'h0, vecs[i].e_instr[20:16]});
      end

      // lw in IF/ID decodes to rs=8, rt=10 during a one-cycle stall.
      step(0, 1, 1, 0, 0, 32'h0, 32'h8D0A0000, 10'h001);
      step(0, 0, 0, 1, 0, 32'h0, 32'h0, 10'h3FF);
      chk("lw_rs", {27'h0, IFID_rs}, 32'd8);
      chk("lw_rt", {27'h0, IFID_rt}, 32'd10);
      chk("lw_stall_state", {30'h0, state}, 32'd1);
      chk("lw_stall_pc", pc, 32'h4);
      step(0, 1, 1, 0, 0, 32'h0, 32'h0, 10'h0);
      chk("lw_run_state", {30'h0, state}, 32'd0);

`ifdef STALL_COUNTER_EN
      // Five stall cycles with reset landing on the third.
      step(1, 1, 0, 0, 0, 32'h0, 32'h0, 10'h0);
      step(0, 0, 0, 0, 0, 32'h0, 32'h0, 10'h0);
      step(0, 0, 0, 0, 0, 32'h0, 32'h0, 10'h0);
      step(1, 0, 0, 0, 0, 32'h0, 32'h0, 10'h0);
      chk("stall_cnt_reset", stall_cycles, 32'd0);
      step(0, 0, 0, 0, 0, 32'h0, 32'h0, 10'h0);
      step(0, 0, 0, 0, 0, 32'h0, 32'h0, 10'h0);
      chk("stall_cnt_after", stall_cycles, 32'd2);
`endif

      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 39) == 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 4) == 0),
              ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : {$urandom} & 32'hFFFF_FFFC,
              $urandom,
              10'($urandom));
         chk_model();
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
